// File: rtl/seq_trigger_monitor.sv
// seq_trigger_monitor
// Ordered-sequence detector for the AES datapath. Watches a WIDTH-bit bus and
// steps through DEPTH programmed patterns (pattern 0 first). Completing the
// sequence raises a sticky trigger and starts rotating an activity register.
//
// Parameters:
//   WIDTH     data bus / pattern width
//   DEPTH     number of patterns in the sequence (1..16)
//   PATTERNS  DEPTH*WIDTH bits, pattern k at PATTERNS[k*WIDTH +: WIDTH]
//   STRICT    1: a non-matching valid word restarts the sequence
//             0: a non-matching word is ignored
//   TIMEOUT   max cycles between consecutive matches (0 disables the timeout)
//   ACT_WIDTH activity register width
//   ACT_INIT  activity reset/reload value
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous return to idle (highest priority)
//   data_valid in   data is sampled on this edge
//   data       in   monitored word
//   step       out  number of patterns matched so far
//   triggered  out  sticky sequence-complete flag
//   activity   out  rotating activity register
module seq_trigger_monitor #(
  parameter int                        WIDTH     = 128,
  parameter int                        DEPTH     = 4,
  parameter logic [DEPTH*WIDTH-1:0]    PATTERNS  = {128'h1,
                                                    128'h0,
                                                    128'h00112233_44556677_8899aabb_ccddeeff,
                                                    128'h3243f6a8_885a308d_313198a2_e0370734},
  parameter bit                        STRICT    = 1'b1,
  parameter int                        TIMEOUT   = 0,
  parameter int                        ACT_WIDTH = 128,
  parameter logic [ACT_WIDTH-1:0]      ACT_INIT  = 128'haaaaaaaa_aaaaaaaa_aaaaaaaa_aaaaaaaa
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         data_valid,
  input  logic [WIDTH-1:0]             data,
  output logic [$clog2(DEPTH+1)-1:0]   step,
  output logic                         triggered,
  output logic [ACT_WIDTH-1:0]         activity
);

  localparam int STEP_W = $clog2(DEPTH+1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(DEPTH - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic {
    SEARCH    = 1'b0,
    TRIGGERED = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [15:0]           tmo_q, tmo_d;
  logic [ACT_WIDTH-1:0]  act_q, act_d;

  logic [WIDTH-1:0]      curPat;
  logic                  hitCur;
  logic                  hitFirst;

  // Select the pattern expected at the current step. Only meaningful in
  // SEARCH, where step_q never exceeds DEPTH-1.
  always_comb begin
    curPat = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (step_q == STEP_W'(k)) begin
        curPat = PATTERNS[k*WIDTH +: WIDTH];
      end
    end
  end

  assign hitCur   = (data == curPat);
  assign hitFirst = (data == PATTERNS[WIDTH-1:0]);

  // Next-state logic. clear beats a match, and a match beats the timeout.
  // The timeout counter only runs in SEARCH with at least one step matched;
  // it expires on the TIMEOUT-th cycle without an advance.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    tmo_d   = tmo_q;
    act_d   = act_q;

    if (clear) begin
      state_d = SEARCH;
      step_d  = '0;
      tmo_d   = '0;
      act_d   = ACT_INIT;
    end else begin
      case (state_q)
        SEARCH: begin
          act_d = ACT_INIT;
          if (data_valid && hitCur) begin
            step_d = step_q + STEP_W'(1);
            tmo_d  = '0;
            if (step_q == STEP_LAST) begin
              state_d = TRIGGERED;
            end
          end else if (data_valid && STRICT) begin
            // Single-word overlap recovery: the offending word may itself
            // start a new sequence.
            step_d = hitFirst ? STEP_W'(1) : '0;
            tmo_d  = '0;
          end else if ((TIMEOUT > 0) && (step_q != '0)) begin
            if (tmo_q == TMO_LAST) begin
              step_d = '0;
              tmo_d  = '0;
            end else begin
              tmo_d = tmo_q + 16'd1;
            end
          end
        end
        TRIGGERED: begin
          // Rotate right by one; written with shifts so ACT_WIDTH=1 is legal.
          act_d = (act_q >> 1) | (act_q << (ACT_WIDTH - 1));
        end
        default: begin
          state_d = SEARCH;
          step_d  = '0;
          tmo_d   = '0;
          act_d   = ACT_INIT;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      step_q  <= '0;
      tmo_q   <= '0;
      act_q   <= ACT_INIT;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      tmo_q   <= tmo_d;
      act_q   <= act_d;
    end
  end

  assign step      = step_q;
  assign triggered = (state_q == TRIGGERED);
  assign activity  = act_q;

endmodule

// File: tb/tb_seq_trigger_monitor.sv
// tb_seq_trigger_monitor
// Self-checking bench for seq_trigger_monitor. Four instances cover the
// default strict detector, lenient matching, an 8-cycle timeout, and a
// DEPTH=1 / 8-bit configuration. Each cycle's expected outputs are pushed to
// a scoreboard queue when the stimulus is driven and popped after the edge.
module tb_seq_trigger_monitor;

  localparam logic [127:0] P0 = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] P1 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] P2 = 128'h0;
  localparam logic [127:0] P3 = 128'h1;
  localparam logic [127:0] JUNK = 128'h5;
  localparam logic [127:0] ACT_A = {4{32'haaaaaaaa}};
  localparam logic [127:0] ACT_5 = {4{32'h55555555}};

  typedef struct packed {
    logic         v;
    logic [127:0] d;
    logic         c;
    logic [2:0]   s;
    logic         t;
    logic [127:0] a;
  } stim_t;

  typedef struct packed {
    logic [2:0]   s;
    logic         t;
    logic [127:0] a;
  } exp_t;

  logic clk;
  logic rst_n;
  logic valid [4];
  logic clr [4];
  logic [127:0] dataIn [4];

  logic [2:0]   stepA, stepB, stepC;
  logic [0:0]   stepD;
  logic         trigA, trigB, trigC, trigD;
  logic [127:0] actA, actB, actC;
  logic [7:0]   actD;

  stim_t stimQ[$];
  exp_t  sbQ[$];
  int vectors = 0;
  int miscompares = 0;

  seq_trigger_monitor dutA (
    .clk(clk), .rst_n(rst_n), .clear(clr[0]), .data_valid(valid[0]),
    .data(dataIn[0]), .step(stepA), .triggered(trigA), .activity(actA)
  );

  seq_trigger_monitor #(.STRICT(1'b0)) dutB (
    .clk(clk), .rst_n(rst_n), .clear(clr[1]), .data_valid(valid[1]),
    .data(dataIn[1]), .step(stepB), .triggered(trigB), .activity(actB)
  );

  seq_trigger_monitor #(.TIMEOUT(8)) dutC (
    .clk(clk), .rst_n(rst_n), .clear(clr[2]), .data_valid(valid[2]),
    .data(dataIn[2]), .step(stepC), .triggered(trigC), .activity(actC)
  );

  seq_trigger_monitor #(
    .WIDTH(8), .DEPTH(1), .PATTERNS(8'h3c),
    .ACT_WIDTH(8), .ACT_INIT(8'ha5)
  ) dutD (
    .clk(clk), .rst_n(rst_n), .clear(clr[3]), .data_valid(valid[3]),
    .data(dataIn[3][7:0]), .step(stepD), .triggered(trigD), .activity(actD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic v, input logic [127:0] d, input logic c,
                     input logic [2:0] s, input logic t, input logic [127:0] a);
    stimQ.push_back({v, d, c, s, t, a});
  endtask

  // Drives one cycle into instance idx (others idle) and records the outputs
  // that instance must show after the edge.
  task automatic driveCycle(input int idx, input stim_t st);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      valid[k] = 1'b0;
      clr[k]   = 1'b0;
    end
    valid[idx]  = st.v;
    dataIn[idx] = st.d;
    clr[idx]    = st.c;
    sbQ.push_back({st.s, st.t, st.a});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      valid[k]  = 1'b0;
      clr[k]    = 1'b0;
      dataIn[k] = '0;
    end
    #12;
    vectors++;
    if (stepA !== 3'd0 || trigA !== 1'b0 || actA !== ACT_A) begin
      miscompares++;
      $display("[TB] FAIL reset_A step=%0d trig=%0b act=%h required step=0 trig=0 act=%h", stepA, trigA, actA, ACT_A);
    end
    vectors++;
    if (stepD !== 1'b0 || trigD !== 1'b0 || actD !== 8'ha5) begin
      miscompares++;
      $display("[TB] FAIL reset_D step=%0d trig=%0b act=%h required step=0 trig=0 act=a5", stepD, trigD, actD);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequence();
    stim_t st;
    exp_t  e;
    add(1, P0, 0, 1, 0, ACT_A);
    add(1, P1, 0, 2, 0, ACT_A);
    add(1, P2, 0, 3, 0, ACT_A);
    add(1, P3, 0, 4, 1, ACT_A);
    add(0, P0, 0, 4, 1, ACT_5);
    add(1, P0, 0, 4, 1, ACT_A);
    while (stimQ.size() > 0) begin
      st = stimQ.pop_front();
      driveCycle(0, st);
      e = sbQ.pop_front();
      vectors++;
      if (stepA !== e.s || trigA !== e.t || actA !== e.a) begin
        miscompares++;
        $display("[TB] FAIL sequence step=%0d trig=%0b act=%h required step=%0d trig=%0b act=%h", stepA, trigA, actA, e.s, e.t, e.a);
      end
    end
  endtask

  task automatic test_clear();
    stim_t st;
    exp_t  e;
    add(0, P0, 0, 4, 1, ACT_5);
    add(0, P0, 0, 4, 1, ACT_A);
    add(0, P0, 0, 4, 1, ACT_5);
    add(1, P0, 1, 0, 0, ACT_A);
    add(0, P0, 0, 0, 0, ACT_A);
    add(0, P1, 0, 0, 0, ACT_A);
    while (stimQ.size() > 0) begin
      st = stimQ.pop_front();
      driveCycle(0, st);
      e = sbQ.pop_front();
      vectors++;
      if (stepA !== e.s || trigA !== e.t || actA !== e.a) begin
        miscompares++;
        $display("[TB] FAIL clear step=%0d trig=%0b act=%h required step=%0d trig=%0b act=%h", stepA, trigA, actA, e.s, e.t, e.a);
      end
    end
  endtask

  task automatic test_strict();
    stim_t st;
    exp_t  e;
    add(1, P0, 0, 1, 0, ACT_A);
    add(1, P1, 0, 2, 0, ACT_A);
    add(1, JUNK, 0, 0, 0, ACT_A);
    add(1, P0, 0, 1, 0, ACT_A);
    add(1, P1, 0, 2, 0, ACT_A);
    add(1, P2, 0, 3, 0, ACT_A);
    add(1, P3, 0, 4, 1, ACT_A);
    while (stimQ.size() > 0) begin
      st = stimQ.pop_front();
      driveCycle(0, st);
      e = sbQ.pop_front();
      vectors++;
      if (stepA !== e.s || trigA !== e.t || actA !== e.a) begin
        miscompares++;
        $display("[TB] FAIL strict step=%0d trig=%0b act=%h required step=%0d trig=%0b act=%h", stepA, trigA, actA, e.s, e.t, e.a);
      end
    end
  endtask

  task automatic test_lenient();
    stim_t st;
    exp_t  e;
    add(1, P0, 0, 1, 0, ACT_A);
    add(0, P1, 0, 1, 0, ACT_A);
    add(1, JUNK, 0, 1, 0, ACT_A);
    add(1, P1, 0, 2, 0, ACT_A);
    add(1, JUNK, 0, 2, 0, ACT_A);
    add(1, P0, 0, 2, 0, ACT_A);
    add(0, P2, 0, 2, 0, ACT_A);
    add(1, P2, 0, 3, 0, ACT_A);
    add(1, JUNK, 0, 3, 0, ACT_A);
    add(1, P3, 0, 4, 1, ACT_A);
    add(0, P3, 0, 4, 1, ACT_5);
    while (stimQ.size() > 0) begin
      st = stimQ.pop_front();
      driveCycle(1, st);
      e = sbQ.pop_front();
      vectors++;
      if (stepB !== e.s || trigB !== e.t || actB !== e.a) begin
        miscompares++;
        $display("[TB] FAIL lenient step=%0d trig=%0b act=%h required step=%0d trig=%0b act=%h", stepB, trigB, actB, e.s, e.t, e.a);
      end
    end
  endtask

  task automatic test_timeout();
    stim_t st;
    exp_t  e;
    add(1, P0, 0, 1, 0, ACT_A);
    add(1, P1, 0, 2, 0, ACT_A);
    for (int i = 1; i < 8; i++) add(0, P2, 0, 2, 0, ACT_A);
    add(0, P2, 0, 0, 0, ACT_A);
    add(1, P0, 0, 1, 0, ACT_A);
    add(1, P1, 0, 2, 0, ACT_A);
    for (int i = 1; i < 8; i++) add(0, P2, 0, 2, 0, ACT_A);
    add(1, P2, 0, 3, 0, ACT_A);
    for (int i = 1; i < 8; i++) add(0, P3, 0, 3, 0, ACT_A);
    add(0, P3, 0, 0, 0, ACT_A);
    while (stimQ.size() > 0) begin
      st = stimQ.pop_front();
      driveCycle(2, st);
      e = sbQ.pop_front();
      vectors++;
      if (stepC !== e.s || trigC !== e.t || actC !== e.a) begin
        miscompares++;
        $display("[TB] FAIL timeout step=%0d trig=%0b act=%h required step=%0d trig=%0b act=%h", stepC, trigC, actC, e.s, e.t, e.a);
      end
    end
  endtask

  task automatic test_depth_one();
    stim_t st;
    exp_t  e;
    add(1, 128'h00, 0, 0, 0, 128'ha5);
    add(1, 128'h3c, 0, 1, 1, 128'ha5);
    add(0, 128'h00, 0, 1, 1, 128'hd2);
    add(1, 128'h00, 0, 1, 1, 128'h69);
    add(1, 128'h3c, 1, 0, 0, 128'ha5);
    while (stimQ.size() > 0) begin
      st = stimQ.pop_front();
      driveCycle(3, st);
      e = sbQ.pop_front();
      vectors++;
      if ({2'b00, stepD} !== e.s || trigD !== e.t || {120'b0, actD} !== e.a) begin
        miscompares++;
        $display("[TB] FAIL depth_one step=%0d trig=%0b act=%h required step=%0d trig=%0b act=%h", stepD, trigD, actD, e.s, e.t, e.a);
      end
    end
  endtask

  task automatic test_async_reset();
    stim_t st;
    exp_t  e;
    add(0, P0, 1, 0, 0, ACT_A);
    add(1, P0, 0, 1, 0, ACT_A);
    add(1, P1, 0, 2, 0, ACT_A);
    add(1, P2, 0, 3, 0, ACT_A);
    while (stimQ.size() > 0) begin
      st = stimQ.pop_front();
      driveCycle(0, st);
      e = sbQ.pop_front();
      vectors++;
      if (stepA !== e.s || trigA !== e.t || actA !== e.a) begin
        miscompares++;
        $display("[TB] FAIL async_setup step=%0d trig=%0b act=%h required step=%0d trig=%0b act=%h", stepA, trigA, actA, e.s, e.t, e.a);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      valid[k] = 1'b0;
      clr[k]   = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (stepA !== 3'd0 || trigA !== 1'b0 || actA !== ACT_A) begin
      miscompares++;
      $display("[TB] FAIL async_reset step=%0d trig=%0b act=%h required step=0 trig=0 act=%h", stepA, trigA, actA, ACT_A);
    end
    vectors++;
    if (stepB !== 3'd0 || trigB !== 1'b0 || actB !== ACT_A) begin
      miscompares++;
      $display("[TB] FAIL async_reset_B step=%0d trig=%0b act=%h required step=0 trig=0 act=%h", stepB, trigB, actB, ACT_A);
    end
    @(negedge clk);
    rst_n = 1'b1;
    add(1, P0, 0, 1, 0, ACT_A);
    while (stimQ.size() > 0) begin
      st = stimQ.pop_front();
      driveCycle(0, st);
      e = sbQ.pop_front();
      vectors++;
      if (stepA !== e.s || trigA !== e.t || actA !== e.a) begin
        miscompares++;
        $display("[TB] FAIL after_reset step=%0d trig=%0b act=%h required step=%0d trig=%0b act=%h", stepA, trigA, actA, e.s, e.t, e.a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_clear();
    test_strict();
    test_lenient();
    test_timeout();
    test_depth_one();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
